// File: rtl/valid_dirty_array.sv
// valid_dirty_array: per-line valid/dirty metadata for the set-associative cache.
// Holds one valid and one dirty bit per (set, way), keeps a registered count of
// valid lines, and runs a flush sweep that invalidates one set per cycle.
module valid_dirty_array #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int CNT_W    = $clog2(NUM_SETS*NUM_WAYS+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    index,
  input  logic [WAY_W-1:0]    way,
  input  logic                set_valid,
  input  logic                invalidate,
  input  logic                set_dirty,
  input  logic                clr_dirty,
  input  logic                flush_req,
  output logic [NUM_WAYS-1:0] valid_out,
  output logic [NUM_WAYS-1:0] dirty_out,
  output logic [CNT_W-1:0]    valid_count,
  output logic                flush_busy,
  output logic                flush_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

  flush_state_t state_q, state_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [CNT_W-1:0]    count_q;
  logic [IDX_W-1:0]    ptr_q;
  logic                busy_q;
  logic                done_q;
  logic                way_ok;
  logic                line_valid;
  logic                last_set;

  // Number of valid ways in one set; used to shrink the count as the sweep clears a set.
  function automatic logic [CNT_W-1:0] pop_ways(input logic [NUM_WAYS-1:0] bits);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      n = n + CNT_W'(bits[w]);
    end
    return n;
  endfunction

  // A way select beyond NUM_WAYS (non power-of-two way counts) addresses nothing.
  assign way_ok     = (32'(way) < NUM_WAYS);
  assign line_valid = valid_q[index][way];
  assign last_set   = (ptr_q == IDX_W'(NUM_SETS-1));

  // Lookup is combinational; during the sweep every lookup is forced to miss.
  always_comb begin
    valid_out = valid_q[index];
    dirty_out = dirty_q[index];
    if (busy_q) begin
      valid_out = '0;
      dirty_out = '0;
    end
  end

  assign valid_count = count_q;
  assign flush_busy  = busy_q;
  assign flush_done  = done_q;

  // Flush FSM state register plus registered busy/done flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SWEEP);
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state logic: one sweep step per set, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = SWEEP;
      SWEEP:   if (last_set)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Metadata array, valid count and sweep pointer; requests are only honoured in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            ptr_q <= '0;
          end
          if (way_ok) begin
            if (invalidate) begin
              valid_q[index][way] <= 1'b0;
              dirty_q[index][way] <= 1'b0;
              if (line_valid) begin
                count_q <= count_q - CNT_W'(1);
              end
            end else begin
              if (set_valid) begin
                valid_q[index][way] <= 1'b1;
                if (!line_valid) begin
                  count_q <= count_q + CNT_W'(1);
                end
              end
              if (set_dirty) begin
                dirty_q[index][way] <= 1'b1;
              end else if (clr_dirty) begin
                dirty_q[index][way] <= 1'b0;
              end
            end
          end
        end
        SWEEP: begin
          valid_q[ptr_q] <= '0;
          dirty_q[ptr_q] <= '0;
          count_q        <= count_q - pop_ways(valid_q[ptr_q]);
          ptr_q          <= ptr_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_valid_dirty_array.sv
// tb_valid_dirty_array: directed checks of fill/count, update priority, flush and reset abort.
module tb_valid_dirty_array;

  localparam int NUM_SETS = 8;
  localparam int NUM_WAYS = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] index;
  logic [0:0] way;
  logic       set_valid;
  logic       invalidate;
  logic       set_dirty;
  logic       clr_dirty;
  logic       flush_req;
  logic [1:0] valid_out;
  logic [1:0] dirty_out;
  logic [4:0] valid_count;
  logic       flush_busy;
  logic       flush_done;

  int checks;
  int failures;

  valid_dirty_array #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .index       (index),
    .way         (way),
    .set_valid   (set_valid),
    .invalidate  (invalidate),
    .set_dirty   (set_dirty),
    .clr_dirty   (clr_dirty),
    .flush_req   (flush_req),
    .valid_out   (valid_out),
    .dirty_out   (dirty_out),
    .valid_count (valid_count),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single rising edge, then return all requests to idle.
  task automatic applyStimulus(input int idx, input int w, input logic sv, input logic inv,
                               input logic sd, input logic cd, input logic fr);
    index      = 3'(idx);
    way        = 1'(w);
    set_valid  = sv;
    invalidate = inv;
    set_dirty  = sd;
    clr_dirty  = cd;
    flush_req  = fr;
    @(posedge clk);
    #1;
    set_valid  = 1'b0;
    invalidate = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    flush_req  = 1'b0;
  endtask

  // Point the lookup at a set and let the combinational outputs settle.
  task automatic lookup(input int idx);
    index = 3'(idx);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    index      = '0;
    way        = '0;
    set_valid  = 1'b0;
    invalidate = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    flush_req  = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_count", 32'(valid_count), 0);
    checkOutput("rst_busy", 32'(flush_busy), 0);
    checkOutput("rst_done", 32'(flush_done), 0);
    checkOutput("rst_valid", 32'(valid_out), 0);
    checkOutput("rst_dirty", 32'(dirty_out), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill all 16 lines; count steps 1..16
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        applyStimulus(s, w, 1, 0, 0, 0, 0);
        checkOutput("fill_count", 32'(valid_count), 32'(s*2 + w + 1));
      end
    end
    for (int s = 0; s < NUM_SETS; s++) begin
      lookup(s);
      checkOutput("fill_valid", 32'(valid_out), 32'h3);
    end

    // Redundant set_valid, then invalidate (3,1)
    applyStimulus(3, 1, 1, 0, 0, 0, 0);
    checkOutput("redundant_count", 32'(valid_count), 16);
    applyStimulus(3, 1, 0, 1, 0, 0, 0);
    checkOutput("inval_count", 32'(valid_count), 15);
    lookup(3);
    checkOutput("inval_valid3", 32'(valid_out), 32'h1);

    // Same-cycle conflicts on (5,0): make it invalid first, then race set/invalidate
    applyStimulus(5, 0, 0, 1, 0, 0, 0);
    checkOutput("inval50_count", 32'(valid_count), 14);
    applyStimulus(5, 0, 1, 1, 0, 0, 0);
    checkOutput("conflict_count", 32'(valid_count), 14);
    lookup(5);
    checkOutput("conflict_valid5", 32'(valid_out), 32'h2);
    applyStimulus(5, 0, 0, 0, 1, 1, 0);
    lookup(5);
    checkOutput("dirty_conflict5", 32'(dirty_out), 32'h1);

    // Plain dirty set and writeback clear on (2,1)
    applyStimulus(2, 1, 0, 0, 1, 0, 0);
    lookup(2);
    checkOutput("dirty_set2", 32'(dirty_out), 32'h2);
    applyStimulus(2, 1, 0, 0, 0, 1, 0);
    lookup(2);
    checkOutput("dirty_clr2", 32'(dirty_out), 32'h0);

    // Bring the array to 10 valid lines
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    checkOutput("preflush_count", 32'(valid_count), 10);

    // Full flush: busy for 8 cycles with lookups missing, set_valid dropped, one done pulse
    applyStimulus(7, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < NUM_SETS; k++) begin
      index = 3'd7;
      checkOutput("sweep_busy", 32'(flush_busy), 1);
      checkOutput("sweep_done", 32'(flush_done), 0);
      checkOutput("sweep_valid", 32'(valid_out), 0);
      checkOutput("sweep_dirty", 32'(dirty_out), 0);
      if (k == 3) begin
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("flush_busy_end", 32'(flush_busy), 0);
    checkOutput("flush_done_pulse", 32'(flush_done), 1);
    @(posedge clk);
    #1;
    checkOutput("flush_done_once", 32'(flush_done), 0);
    checkOutput("flush_count", 32'(valid_count), 0);
    for (int s = 0; s < NUM_SETS; s++) begin
      lookup(s);
      checkOutput("flush_valid", 32'(valid_out), 0);
      checkOutput("flush_dirty", 32'(dirty_out), 0);
    end

    // Reset mid-flush
    applyStimulus(2, 0, 1, 0, 0, 0, 0);
    applyStimulus(6, 1, 1, 0, 1, 0, 0);
    checkOutput("prereset_count", 32'(valid_count), 2);
    applyStimulus(6, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midflush_busy", 32'(flush_busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(flush_busy), 0);
    checkOutput("abort_done", 32'(flush_done), 0);
    checkOutput("abort_count", 32'(valid_count), 0);
    lookup(6);
    checkOutput("abort_valid6", 32'(valid_out), 0);
    checkOutput("abort_dirty6", 32'(dirty_out), 0);
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(flush_done), 0);
    end
    applyStimulus(4, 1, 1, 0, 0, 0, 0);
    checkOutput("post_reset_count", 32'(valid_count), 1);
    lookup(4);
    checkOutput("post_reset_valid4", 32'(valid_out), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
